// File: rtl/silent_interpolator.sv
// -----------------------------------------------------------------------------
// silent_interpolator
//
// Silencer stage that sits directly after the step calculator. Each frame
// carries one beat per transducer. For every beat, the stored intensity and
// phase of that transducer move toward the requested targets, but never by
// more than the per-beat update rates:
//   - Intensity is clamped linearly toward its target.
//   - Phase follows the shorter arc of the 16-bit phase circle.
// The upper bytes of the updated values go to the PWM/modulation stage.
// Output latency is fixed at two cycles.
//
// Parameters
//   DEPTH                  transducers per frame (beats per frame), >= 2
//
// Ports
//   CLK                    system clock
//   RST                    synchronous, active-high reset
//   DIN_VALID              qualifies one transducer beat on the input buses
//   INTENSITY_IN  [15:0]   target intensity
//   PHASE_IN      [15:0]   target phase (65536 counts = 2*pi)
//   UPDATE_RATE_INTENSITY  maximum intensity change per update
//   UPDATE_RATE_PHASE      maximum phase change per update
//   INTENSITY_OUT [7:0]    updated intensity, bits [15:8]
//   PHASE_OUT     [7:0]    updated phase, bits [15:8]
//   DOUT_VALID             qualifies the output beat
// -----------------------------------------------------------------------------
module silent_interpolator #(
    parameter int DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic [15:0] INTENSITY_IN,
    input  logic [15:0] PHASE_IN,
    input  logic [15:0] UPDATE_RATE_INTENSITY,
    input  logic [15:0] UPDATE_RATE_PHASE,
    output logic [7:0]  INTENSITY_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_VALID
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // The stored values live in flops rather than RAM, so that a single
    // reset edge clears every transducer before the next frame starts.
    logic [15:0] cur_int_q [DEPTH];
    logic [15:0] cur_int_d [DEPTH];
    logic [15:0] cur_ph_q  [DEPTH];
    logic [15:0] cur_ph_d  [DEPTH];

    logic [IDX_W-1:0] idx_q, idx_d;

    // Stage 1 registers: beat attributes plus the stored values for its index
    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [15:0]      s1_tgt_int_q, s1_tgt_int_d;
    logic [15:0]      s1_tgt_ph_q, s1_tgt_ph_d;
    logic [15:0]      s1_rate_int_q, s1_rate_int_d;
    logic [15:0]      s1_rate_ph_q, s1_rate_ph_d;
    logic [15:0]      s1_cur_int_q, s1_cur_int_d;
    logic [15:0]      s1_cur_ph_q, s1_cur_ph_d;

    // Stage 2 output registers
    logic [7:0] out_int_q, out_int_d;
    logic [7:0] out_ph_q, out_ph_d;
    logic       out_valid_q, out_valid_d;

    logic [15:0] nxt_int;
    logic [15:0] nxt_ph;
    logic [16:0] int_sum;
    logic [15:0] int_gap_down;
    logic [15:0] ph_fwd;
    logic [15:0] ph_back;

    // Stage 1: advance the beat index and fetch the stored values for it.
    // A transducer index only comes back DEPTH beats later, so this read
    // never collides with the stage 2 write-back.
    always_comb begin
        idx_d = idx_q;
        if (DIN_VALID) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        s1_valid_d    = DIN_VALID;
        s1_idx_d      = idx_q;
        s1_tgt_int_d  = INTENSITY_IN;
        s1_tgt_ph_d   = PHASE_IN;
        s1_rate_int_d = UPDATE_RATE_INTENSITY;
        s1_rate_ph_d  = UPDATE_RATE_PHASE;
        s1_cur_int_d  = cur_int_q[idx_q];
        s1_cur_ph_d   = cur_ph_q[idx_q];
    end

    // Intensity step. The upward sum is formed in 17 bits so that a large
    // rate cannot wrap past the target. The downward case compares the
    // remaining gap against the rate, which avoids any underflow.
    always_comb begin
        int_sum      = {1'b0, s1_cur_int_q} + {1'b0, s1_rate_int_q};
        int_gap_down = s1_cur_int_q - s1_tgt_int_q;
        nxt_int      = s1_cur_int_q;
        if (s1_tgt_int_q > s1_cur_int_q) begin
            nxt_int = (int_sum >= {1'b0, s1_tgt_int_q}) ? s1_tgt_int_q : int_sum[15:0];
        end else if (s1_tgt_int_q < s1_cur_int_q) begin
            nxt_int = (int_gap_down <= s1_rate_int_q) ? s1_tgt_int_q
                                                      : s1_cur_int_q - s1_rate_int_q;
        end
    end

    // Phase step along the shorter arc. ph_fwd is the forward distance
    // modulo 2^16, and ph_back is the complementary backward distance.
    // An exact half-turn is treated as forward. Wrap-around through 0 is
    // intended, so the sums are left to overflow.
    always_comb begin
        ph_fwd  = s1_tgt_ph_q - s1_cur_ph_q;
        ph_back = s1_cur_ph_q - s1_tgt_ph_q;
        nxt_ph  = s1_cur_ph_q;
        if (ph_fwd == 16'h0000) begin
            nxt_ph = s1_cur_ph_q;
        end else if (ph_fwd <= 16'h8000) begin
            nxt_ph = (ph_fwd <= s1_rate_ph_q) ? s1_tgt_ph_q : s1_cur_ph_q + s1_rate_ph_q;
        end else begin
            nxt_ph = (ph_back <= s1_rate_ph_q) ? s1_tgt_ph_q : s1_cur_ph_q - s1_rate_ph_q;
        end
    end

    // Stage 2: write the updated values back and register the outputs.
    // The outputs keep their previous value while there is no beat.
    always_comb begin
        cur_int_d   = cur_int_q;
        cur_ph_d    = cur_ph_q;
        out_int_d   = out_int_q;
        out_ph_d    = out_ph_q;
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            cur_int_d[s1_idx_q] = nxt_int;
            cur_ph_d[s1_idx_q]  = nxt_ph;
            out_int_d           = nxt_int[15:8];
            out_ph_d            = nxt_ph[15:8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                cur_int_q[i] <= '0;
                cur_ph_q[i]  <= '0;
            end
            idx_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_idx_q      <= '0;
            s1_tgt_int_q  <= '0;
            s1_tgt_ph_q   <= '0;
            s1_rate_int_q <= '0;
            s1_rate_ph_q  <= '0;
            s1_cur_int_q  <= '0;
            s1_cur_ph_q   <= '0;
            out_int_q     <= '0;
            out_ph_q      <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            cur_int_q     <= cur_int_d;
            cur_ph_q      <= cur_ph_d;
            idx_q         <= idx_d;
            s1_valid_q    <= s1_valid_d;
            s1_idx_q      <= s1_idx_d;
            s1_tgt_int_q  <= s1_tgt_int_d;
            s1_tgt_ph_q   <= s1_tgt_ph_d;
            s1_rate_int_q <= s1_rate_int_d;
            s1_rate_ph_q  <= s1_rate_ph_d;
            s1_cur_int_q  <= s1_cur_int_d;
            s1_cur_ph_q   <= s1_cur_ph_d;
            out_int_q     <= out_int_d;
            out_ph_q      <= out_ph_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign INTENSITY_OUT = out_int_q;
    assign PHASE_OUT     = out_ph_q;
    assign DOUT_VALID    = out_valid_q;

endmodule

// File: tb/tb_silent_interpolator.sv
// -----------------------------------------------------------------------------
// tb_silent_interpolator
//
// Directed testbench for silent_interpolator, using a scoreboard.
//
// Every accepted input beat is run through a behavioural model of the
// per-transducer intensity and phase state. The expected output byte pair
// is pushed onto a queue at that point. On each falling edge, the monitor
// does the following:
//   - checks DOUT_VALID against the input-valid history delayed by two,
//   - pops and compares the output bytes whenever a beat comes out,
//   - checks that the outputs hold their value when no beat comes out.
// -----------------------------------------------------------------------------
module tb_silent_interpolator;

    localparam int DEPTH = 249;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DIN_VALID;
    logic [15:0] INTENSITY_IN;
    logic [15:0] PHASE_IN;
    logic [15:0] UPDATE_RATE_INTENSITY;
    logic [15:0] UPDATE_RATE_PHASE;
    logic [7:0]  INTENSITY_OUT;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_VALID;

    int checks = 0;
    int failures = 0;

    logic [15:0] mdlInt [DEPTH];
    logic [15:0] mdlPh  [DEPTH];
    int          mdlIdx;
    logic [15:0] expQ [$];
    logic [1:0]  validHist;
    logic [15:0] lastOut;
    bit          monitorOn = 1'b0;

    silent_interpolator #(.DEPTH(DEPTH)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .DIN_VALID             (DIN_VALID),
        .INTENSITY_IN          (INTENSITY_IN),
        .PHASE_IN              (PHASE_IN),
        .UPDATE_RATE_INTENSITY (UPDATE_RATE_INTENSITY),
        .UPDATE_RATE_PHASE     (UPDATE_RATE_PHASE),
        .INTENSITY_OUT         (INTENSITY_OUT),
        .PHASE_OUT             (PHASE_OUT),
        .DOUT_VALID            (DOUT_VALID)
    );

    // Free-running clock with a 10-time-unit period
    always #5 CLK = ~CLK;

    // Input-valid history. DOUT_VALID must equal DIN_VALID from two edges back.
    always @(posedge CLK) begin
        if (RST) validHist <= 2'b00;
        else     validHist <= {validHist[0], DIN_VALID};
    end

    // Reference intensity step: linear clamp toward the target
    function automatic logic [15:0] modelIntensity(input logic [15:0] c, input logic [15:0] t,
                                                   input logic [15:0] r);
        int ci, ti, ri;
        ci = int'(c);
        ti = int'(t);
        ri = int'(r);
        if (ti > ci) return (ci + ri >= ti) ? t : 16'(ci + ri);
        if (ti < ci) return (ci - ri <= ti) ? t : 16'(ci - ri);
        return c;
    endfunction

    // Reference phase step: shorter arc on the 16-bit circle, half-turn goes forward
    function automatic logic [15:0] modelPhase(input logic [15:0] c, input logic [15:0] t,
                                               input logic [15:0] r);
        int ci, ti, ri, d;
        ci = int'(c);
        ti = int'(t);
        ri = int'(r);
        d  = (ti - ci + 65536) % 65536;
        if (d == 0) return c;
        if (d <= 32768) return (ri >= d) ? t : 16'((ci + ri) % 65536);
        return (ri >= 65536 - d) ? t : 16'((ci - ri + 65536) % 65536);
    endfunction

    function automatic logic [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    // Drive one cycle of input. If the beat is valid, advance the model and
    // queue the expected output.
    task automatic applyStimulus(input logic v, input logic [15:0] ti, input logic [15:0] tp,
                                 input logic [15:0] ri, input logic [15:0] rp);
        logic [15:0] ni, np;
        DIN_VALID             = v;
        INTENSITY_IN          = ti;
        PHASE_IN              = tp;
        UPDATE_RATE_INTENSITY = ri;
        UPDATE_RATE_PHASE     = rp;
        @(posedge CLK);
        if (v) begin
            ni = modelIntensity(mdlInt[mdlIdx], ti, ri);
            np = modelPhase(mdlPh[mdlIdx], tp, rp);
            mdlInt[mdlIdx] = ni;
            mdlPh[mdlIdx]  = np;
            expQ.push_back({ni[15:8], np[15:8]});
            mdlIdx = (mdlIdx == DEPTH - 1) ? 0 : mdlIdx + 1;
        end
        #1;
        DIN_VALID = 1'b0;
    endtask

    // Drive one full frame with the same target and rate on every beat
    task automatic runFrame(input logic [15:0] ti, input logic [15:0] tp,
                            input logic [15:0] ri, input logic [15:0] rp);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, ti, tp, ri, rp);
    endtask

    // Reset cycle. Beats still in flight are dropped from the scoreboard.
    task automatic doReset();
        RST       = 1'b1;
        DIN_VALID = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < DEPTH; i++) begin
            mdlInt[i] = '0;
            mdlPh[i]  = '0;
        end
        mdlIdx  = 0;
        lastOut = '0;
        expQ.delete();
        #1;
        RST = 1'b0;
    endtask

    task automatic checkResetState();
        checks++;
        assert (DOUT_VALID === 1'b0) else begin
            failures++;
            $error("[TB] FAIL reset_valid observed=%b expected=0", DOUT_VALID);
        end
        checks++;
        assert (INTENSITY_OUT === 8'h00) else begin
            failures++;
            $error("[TB] FAIL reset_intensity observed=%h expected=00", INTENSITY_OUT);
        end
        checks++;
        assert (PHASE_OUT === 8'h00) else begin
            failures++;
            $error("[TB] FAIL reset_phase observed=%h expected=00", PHASE_OUT);
        end
    endtask

    // Falling-edge monitor: valid timing, scoreboard pop, and output hold
    task automatic checkOutput();
        logic [15:0] exp;
        checks++;
        assert (DOUT_VALID === validHist[1]) else begin
            failures++;
            $error("[TB] FAIL dout_valid observed=%b expected=%b", DOUT_VALID, validHist[1]);
        end
        if (DOUT_VALID === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL scoreboard_empty observed=%h%h expected=none",
                       INTENSITY_OUT, PHASE_OUT);
            end else begin
                exp = expQ.pop_front();
                checks++;
                assert ({INTENSITY_OUT, PHASE_OUT} === exp) else begin
                    failures++;
                    $error("[TB] FAIL beat_out observed=%h/%h expected=%h/%h",
                           INTENSITY_OUT, PHASE_OUT, exp[15:8], exp[7:0]);
                end
                lastOut = {INTENSITY_OUT, PHASE_OUT};
            end
        end else begin
            checks++;
            assert ({INTENSITY_OUT, PHASE_OUT} === lastOut) else begin
                failures++;
                $error("[TB] FAIL output_hold observed=%h/%h expected=%h/%h",
                       INTENSITY_OUT, PHASE_OUT, lastOut[15:8], lastOut[7:0]);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (monitorOn) checkOutput();
    end

    initial begin
        int beats;
        RST                   = 1'b1;
        DIN_VALID             = 1'b0;
        INTENSITY_IN          = '0;
        PHASE_IN              = '0;
        UPDATE_RATE_INTENSITY = '0;
        UPDATE_RATE_PHASE     = '0;
        repeat (2) @(posedge CLK);
        doReset();
        checkResetState();
        monitorOn = 1'b1;

        // Intensity ramp: 0x04, 0x08, 0x0C, 0x10, then it stays at 0x10
        $display("[TB] intensity ramp");
        for (int f = 0; f < 5; f++) runFrame(16'h1000, 16'h0000, 16'h0400, 16'h0000);

        // Downward step that lands exactly on the target (0x0F)
        $display("[TB] intensity down clamp");
        runFrame(16'h0F00, 16'h0000, 16'h0400, 16'h0000);

        // Full-scale step from zero must not overflow (0xFF)
        $display("[TB] intensity full scale");
        doReset();
        checkResetState();
        runFrame(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);

        // Phase wraps backward through zero: 0x0100 -> 0x0080 -> 0x0000 -> 0xFF80
        $display("[TB] phase shortest arc");
        doReset();
        runFrame(16'h0000, 16'h0100, 16'h0000, 16'hFFFF);
        for (int f = 0; f < 3; f++) runFrame(16'h0000, 16'hFF00, 16'h0000, 16'h0080);

        // Half-turn tie from zero moves forward to 0x1000
        $display("[TB] phase tie");
        doReset();
        runFrame(16'h0000, 16'h8000, 16'h0000, 16'h1000);

        // Load random stored values, then apply a rate-0 frame with different targets
        $display("[TB] zero rate");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, rnd16(), rnd16(), 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, rnd16(), rnd16(), 16'h0000, 16'h0000);

        // Two frames of random beats with idle gaps, including the index wrap
        $display("[TB] gapped stream");
        beats = 0;
        while (beats < 2 * DEPTH) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, rnd16(), rnd16(), rnd16(), rnd16());
            end else begin
                applyStimulus(1'b1, rnd16(), rnd16(), {4'h0, rnd16() >> 4}, {4'h0, rnd16() >> 4});
                beats++;
            end
        end

        // Reset after 100 beats of a frame; the next frame starts from zero at index 0
        $display("[TB] mid-frame reset");
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, rnd16(), rnd16(), rnd16(), rnd16());
        doReset();
        runFrame(16'h2000, 16'h0000, 16'h1000, 16'h0000);

        repeat (4) applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        monitorOn = 1'b0;

        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
